fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the pipelined 16-bit core. Holds the PC and drives the instruction-memory address. Registers the fetched word into the IF/ID pipeline register. Resolves B/BR redirects presented by the decode stage against the N/Z/V flag register output, and freezes fetch on HLT.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`, input, 1, core clock; all state updates on the rising edge.
- `rst`, input, 1, reset; synchronous, active-high.
- `imem_addr`, output, 16, fetch address; equals the PC register.
- `imem_data`, input, 16, instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `stall`, input, 1, hazard hold from decode; freezes the PC, IF/ID and state.
- `br_valid`, input, 1, a B or BR instruction is in ID this cycle.
- `br_is_reg`, input, 1, 0 = B (PC-relative), 1 = BR (register target).
- `br_cond`, input, 3, condition field ccc.
- `br_imm`, input, 9, B offset in words, signed.
- `br_reg`, input, 16, BR target register value.
- `flags`, input, 3, {N, Z, V} from the flag register.
- `if_id_instr`, output, 16, registered instruction.
- `if_id_pc_plus2`, output, 16, registered PC+2 of that instruction.
- `if_id_valid`, output, 1, IF/ID holds a live instruction.
- `halted`, output, 1, fetch is frozen by HLT.

## Operation
- State machine with two states, RUN and HALTED. The state encoding is 1 bit.
- **Condition decode (ccc):**
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 UN: always
- `taken` = `br_valid` & cond-true & !`stall`.
- **Targets:**
  - B: `if_id_pc_plus2` + (sext(`br_imm`) << 1).
  - BR: `br_reg`.
  - 16-bit modulo arithmetic; no overflow detection.
- **RUN, priority high to low:**
  - `stall` = 1: hold the PC, IF/ID and state.
  - `taken` = 1: PC ← target; IF/ID ← valid=0 (the word in IF is squashed). The state stays RUN even if that word is HLT.
  - Fetched word has opcode 4'hF (HLT): IF/ID ← {HLT, PC+2, valid=1}; PC holds; next state is HALTED.
  - Otherwise: IF/ID ← {`imem_data`, PC+2, valid=1}; PC ← PC+2.
- **HALTED:**
  - PC holds; IF/ID ← valid=0 every non-stalled cycle (bubbles drain).
  - `br_valid` is ignored.
  - Only `rst` exits the state.
- The PC+2 wrap 16'hFFFE → 16'h0000 is legal and silent.

## Timing
- **Reset values:**
  - PC = `RESET_PC`
  - state = RUN
  - `if_id_instr` = 16'h0000, `if_id_pc_plus2` = 16'h0000, `if_id_valid` = 0
  - `halted` = 0
- Reset overrides `stall` and `taken`, and applies mid-halt or mid-branch.
- Fetch latency: the word at PC appears on `if_id_*` one edge later.
- **Taken branch:**
  - It is resolved in the cycle it sits in ID.
  - The target is fetched in the next cycle.
  - Penalty: exactly one bubble (`if_id_valid` = 0 for one cycle).
- Not-taken branch: zero penalty.
- **Stall:**
  - It lasts any number of cycles and outputs are unchanged throughout.
  - `br_valid` is re-evaluated when `stall` drops.
- **HLT:**
  - `halted` rises on the edge that latches HLT into IF/ID.
  - The HLT instruction itself reaches ID with `if_id_valid` = 1.
  - `halted` is a registered, glitch-free decode of state.
- **Simultaneous events:**
  - A taken branch with HLT in IF: the branch wins and HLT is discarded.
  - `stall` with HLT in IF: hold, no transition.

## Structure
- **Shared core package/header:**
  - opcode constants: HLT = 4'hF, B = 4'hC, BR = 4'hD
  - ccc constants NE..UN
  - state encoding
  - flag bit positions: N = 2, Z = 1, V = 0
- **Sub-module `cond_eval`:** combinational (`br_cond`, `flags`) → `cond_true`, reused by verification as a reference.
- The PC and IF/ID fields are built from the existing per-bit enabled-DFF primitive: 16-bit PC, 16+16+1 IF/ID.
  - Write enable for both is !`stall`.
  - The PC's enable is also gated by RUN-and-not-HLT unless `taken`.
- One adder for PC+2, one for the B target.

## Test plan
- Reset, then 4 cycles with no stall and imem returning 16'h1234 → `imem_addr` steps 0, 2, 4, 6. IF/ID shows 16'h1234 with pc_plus2 2, 4, 6; valid goes 0, 1, 1, 1.
- B with ccc = 001, flags Z = 1, `br_imm` = 9'h1FE (−2), `if_id_pc_plus2` = 16'h0010 → next PC 16'h000C, one cycle with valid = 0. Same stimulus with Z = 0 → PC continues sequentially, no bubble.
- BR with ccc = 111, `br_reg` = 16'hABCE → next PC 16'hABCE. Sweep all 8 ccc values × 8 flag combinations against the `cond_eval` table.
- `stall` held 3 cycles while `br_valid` = 1 and the condition is true → PC and IF/ID are frozen, no redirect. The redirect occurs on the first edge after `stall` drops.
- HLT (16'hF000) fetched at PC 16'h0008 → IF/ID holds HLT with pc_plus2 16'h000A; `halted` = 1. The PC stays 16'h0008 indefinitely and valid = 0 thereafter.
- HLT in IF while a taken B is in ID → HLT squashed, `halted` stays 0, PC = target. Separately, assert `rst` while HALTED → PC = 16'h0000, `halted` = 0, and the next cycle fetches normally.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 16-bit core front end:
// opcodes, branch conditions, fetch state and flag layout.
package fetch_stage_pkg;

   localparam logic [3:0] OP_HLT = 4'hF;
   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;

   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [2:0] {
      CC_NE = 3'd0,
      CC_EQ = 3'd1,
      CC_GT = 3'd2,
      CC_LT = 3'd3,
      CC_GE = 3'd4,
      CC_LE = 3'd5,
      CC_OV = 3'd6,
      CC_UN = 3'd7
   } ccc_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_plus2;
      logic        valid;
   } if_id_t;

   // Word offset of a B instruction turned into a byte offset.
   function automatic logic [15:0] b_offset(logic [8:0] imm);
      return {{6{imm[8]}}, imm, 1'b0};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between fetch, instruction memory and decode:
// imem bus, branch resolution inputs and the IF/ID register.
interface fetch_stage_if;

   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        stall;
   logic        br_valid;
   logic        br_is_reg;
   logic [2:0]  br_cond;
   logic [8:0]  br_imm;
   logic [15:0] br_reg;
   logic [2:0]  flags;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus2;
   logic        if_id_valid;
   logic        halted;

   modport master (
      output imem_addr, if_id_instr, if_id_pc_plus2,
      output if_id_valid, halted,
      input  imem_data, stall, br_valid, br_is_reg,
      input  br_cond, br_imm, br_reg, flags
   );

   modport slave (
      input  imem_addr, if_id_instr, if_id_pc_plus2,
      input  if_id_valid, halted,
      output imem_data, stall, br_valid, br_is_reg,
      output br_cond, br_imm, br_reg, flags
   );

endinterface

// File: rtl/fetch_stage_cond_eval.sv
// Branch condition evaluator: ccc field against the
// {N, Z, V} flag register output.
module cond_eval
   import fetch_stage_pkg::*;
(
   input  logic [2:0] br_cond,
   input  logic [2:0] flags,
   output logic       cond_true
);

   logic n;
   logic z;
   logic v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];

   // Decode the condition field into a single truth bit.
   always_comb begin
      cond_true = 1'b0;
      unique case (ccc_t'(br_cond))
         CC_NE: cond_true = !z;
         CC_EQ: cond_true = z;
         CC_GT: cond_true = !z && !n;
         CC_LT: cond_true = n;
         CC_GE: cond_true = z || (!z && !n);
         CC_LE: cond_true = n || z;
         CC_OV: cond_true = v;
         CC_UN: cond_true = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_stage_en_dff.sv
// Enabled D flip-flop bank with synchronous active-high
// reset; the building block for PC and IF/ID state.
module fetch_stage_en_dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable, reset wins.
   always_ff @(posedge clk) begin
      if (rst)     q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, IF/ID register,
// B/BR redirect resolution and HLT freeze.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   state_t      state_q;
   state_t      state_d;
   logic        run;

   logic [15:0] pc_q;
   logic [15:0] pc_d;
   logic        pc_en;
   logic [15:0] pc_plus2;
   logic [15:0] b_target;
   logic [15:0] target;

   logic        cond_true;
   logic        taken;
   logic        is_hlt;

   if_id_t      ifid_q;
   logic        fields_en;
   logic        valid_en;
   logic        valid_d;

   cond_eval u_cond (
      .br_cond   (bus.br_cond),
      .flags     (bus.flags),
      .cond_true (cond_true)
   );

   assign pc_plus2 = pc_q + 16'd2;
   assign b_target = ifid_q.pc_plus2 + b_offset(bus.br_imm);
   assign target   = bus.br_is_reg ? bus.br_reg : b_target;
   assign is_hlt   = bus.imem_data[15:12] == OP_HLT;

   // Branches are ignored once halted and wait out a stall.
   assign taken = bus.br_valid & cond_true & ~bus.stall & run;

   // A HLT in IF parks the PC unless a branch squashes it.
   assign pc_en = ~bus.stall & (taken | (run & ~is_hlt));
   assign pc_d  = taken ? target : pc_plus2;

   // Bubbles keep the last live word; only valid drops.
   assign valid_en  = ~bus.stall;
   assign valid_d   = run & ~taken;
   assign fields_en = ~bus.stall & run & ~taken;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // Next state: enter HALTED when a HLT is latched.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && !bus.stall && !taken && is_hlt)
         state_d = ST_HALTED;
   end

   // State decode; halted is the flop bit itself.
   always_comb begin
      run        = state_q == ST_RUN;
      bus.halted = state_q == ST_HALTED;
   end

   fetch_stage_en_dff #(.W(16), .RST_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc_q)
   );

   fetch_stage_en_dff #(.W(16), .RST_VAL(16'h0000)) u_instr (
      .clk (clk),
      .rst (rst),
      .en  (fields_en),
      .d   (bus.imem_data),
      .q   (ifid_q.instr)
   );

   fetch_stage_en_dff #(.W(16), .RST_VAL(16'h0000)) u_pcp2 (
      .clk (clk),
      .rst (rst),
      .en  (fields_en),
      .d   (pc_plus2),
      .q   (ifid_q.pc_plus2)
   );

   fetch_stage_en_dff #(.W(1), .RST_VAL(1'b0)) u_valid (
      .clk (clk),
      .rst (rst),
      .en  (valid_en),
      .d   (valid_d),
      .q   (ifid_q.valid)
   );

   assign bus.imem_addr      = pc_q;
   assign bus.if_id_instr    = ifid_q.instr;
   assign bus.if_id_pc_plus2 = ifid_q.pc_plus2;
   assign bus.if_id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cases
// plus random traffic against a behavioural model.
module tb_fetch_stage;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [256];

   assign bus.imem_data = mem[bus.imem_addr[8:1]];

   logic [15:0] m_pc;
   logic [15:0] m_instr;
   logic [15:0] m_pcp2;
   logic        m_valid;
   logic        m_halt;
   bit          chk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [15:0] act,
                      logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit cond_ok(logic [2:0] c,
                                  logic [2:0] f);
      bit n, z, v;
      n = f[2];
      z = f[1];
      v = f[0];
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic set_in(bit s, bit bv, bit isreg,
                         logic [2:0] c, logic [8:0] imm,
                         logic [15:0] r, logic [2:0] f);
      bus.stall     = s;
      bus.br_valid  = bv;
      bus.br_is_reg = isreg;
      bus.br_cond   = c;
      bus.br_imm    = imm;
      bus.br_reg    = r;
      bus.flags     = f;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'd0);
   endtask

   // One clock: predict the next state, take the edge,
   // then return on the following falling edge.
   task automatic tick();
      logic [15:0] w, n_pc, n_instr, n_pcp2;
      logic        n_valid, n_halt;
      int          off;
      w       = mem[m_pc[8:1]];
      n_pc    = m_pc;
      n_instr = m_instr;
      n_pcp2  = m_pcp2;
      n_valid = m_valid;
      n_halt  = m_halt;
      if (rst) begin
         n_pc    = 16'h0000;
         n_instr = 16'h0000;
         n_pcp2  = 16'h0000;
         n_valid = 1'b0;
         n_halt  = 1'b0;
      end else if (bus.stall) begin
         n_pc = m_pc;
      end else if (m_halt) begin
         n_valid = 1'b0;
      end else if (bus.br_valid &&
                   cond_ok(bus.br_cond, bus.flags)) begin
         off = $signed(bus.br_imm);
         if (bus.br_is_reg) n_pc = bus.br_reg;
         else n_pc = m_pcp2 + 16'(off * 2);
         n_valid = 1'b0;
      end else begin
         n_instr = w;
         n_pcp2  = 16'(m_pc + 16'd2);
         n_valid = 1'b1;
         if (w[15:12] == 4'hF) n_halt = 1'b1;
         else n_pc = 16'(m_pc + 16'd2);
      end
      @(posedge clk);
      m_pc    = n_pc;
      m_instr = n_instr;
      m_pcp2  = n_pcp2;
      m_valid = n_valid;
      m_halt  = n_halt;
      if (rst) chk_en = 1'b1;
      @(negedge clk);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_addr", bus.imem_addr, m_pc);
         chk("if_id_valid", 16'(bus.if_id_valid),
             16'(m_valid));
         chk("halted", 16'(bus.halted), 16'(m_halt));
         if (m_valid) begin
            chk("if_id_instr", bus.if_id_instr, m_instr);
            chk("if_id_pc_plus2", bus.if_id_pc_plus2,
                m_pcp2);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] s_pc, exp_pc, w;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
      m_pc    = 16'h0000;
      m_instr = 16'h0000;
      m_pcp2  = 16'h0000;
      m_valid = 1'b0;
      m_halt  = 1'b0;

      do_reset();
      chk("rst_addr", bus.imem_addr, 16'h0000);
      chk("rst_valid", 16'(bus.if_id_valid), 16'h0000);
      chk("rst_halted", 16'(bus.halted), 16'h0000);
      chk("rst_instr", bus.if_id_instr, 16'h0000);
      chk("rst_pcp2", bus.if_id_pc_plus2, 16'h0000);

      for (int i = 1; i < 4; i++) begin
         tick();
         chk("seq_addr", bus.imem_addr, 16'(2 * i));
         chk("seq_pcp2", bus.if_id_pc_plus2, 16'(2 * i));
         chk("seq_valid", 16'(bus.if_id_valid), 16'h0001);
         chk("seq_instr", bus.if_id_instr, 16'h1234);
      end

      repeat (5) tick();
      chk("pre_b_pcp2", bus.if_id_pc_plus2, 16'h0010);
      set_in(1'b0, 1'b1, 1'b0, 3'b001, 9'h1FE, 16'h0, 3'b010);
      tick();
      idle();
      chk("b_taken_addr", bus.imem_addr, 16'h000C);
      chk("b_bubble", 16'(bus.if_id_valid), 16'h0000);
      tick();
      chk("b_target_fetch", bus.imem_addr, 16'h000E);
      chk("b_target_pcp2", bus.if_id_pc_plus2, 16'h000E);

      do_reset();
      repeat (8) tick();
      set_in(1'b0, 1'b1, 1'b0, 3'b001, 9'h1FE, 16'h0, 3'b000);
      tick();
      idle();
      chk("b_nt_addr", bus.imem_addr, 16'h0012);
      chk("b_nt_valid", 16'(bus.if_id_valid), 16'h0001);
      chk("b_nt_pcp2", bus.if_id_pc_plus2, 16'h0012);

      set_in(1'b0, 1'b1, 1'b1, 3'b111, 9'h0, 16'hABCE, 3'b000);
      tick();
      idle();
      chk("br_addr", bus.imem_addr, 16'hABCE);
      chk("br_bubble", 16'(bus.if_id_valid), 16'h0000);

      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            s_pc = m_pc;
            exp_pc = cond_ok(3'(c), 3'(f)) ? 16'h0100
                                           : 16'(s_pc + 16'd2);
            set_in(1'b0, 1'b1, 1'b1, 3'(c), 9'h0, 16'h0100,
                   3'(f));
            tick();
            chk("ccc_sweep", bus.imem_addr, exp_pc);
         end
      end
      idle();
      tick();

      s_pc = m_pc;
      set_in(1'b1, 1'b1, 1'b1, 3'b111, 9'h0, 16'h0040, 3'b000);
      repeat (3) begin
         tick();
         chk("stall_hold", bus.imem_addr, s_pc);
      end
      bus.stall = 1'b0;
      tick();
      idle();
      chk("stall_release", bus.imem_addr, 16'h0040);
      chk("stall_bubble", 16'(bus.if_id_valid), 16'h0000);

      mem[4] = 16'hF000;
      do_reset();
      repeat (4) tick();
      tick();
      chk("hlt_instr", bus.if_id_instr, 16'hF000);
      chk("hlt_pcp2", bus.if_id_pc_plus2, 16'h000A);
      chk("hlt_valid", 16'(bus.if_id_valid), 16'h0001);
      chk("hlt_halted", 16'(bus.halted), 16'h0001);
      chk("hlt_addr", bus.imem_addr, 16'h0008);
      set_in(1'b0, 1'b1, 1'b1, 3'b111, 9'h0, 16'h0100, 3'b000);
      repeat (3) begin
         tick();
         chk("halt_addr", bus.imem_addr, 16'h0008);
         chk("halt_valid", 16'(bus.if_id_valid), 16'h0000);
         chk("halt_flag", 16'(bus.halted), 16'h0001);
      end

      do_reset();
      chk("unhalt_addr", bus.imem_addr, 16'h0000);
      chk("unhalt_flag", 16'(bus.halted), 16'h0000);
      tick();
      chk("unhalt_fetch", bus.imem_addr, 16'h0002);
      chk("unhalt_valid", 16'(bus.if_id_valid), 16'h0001);
      chk("unhalt_instr", bus.if_id_instr, 16'h1234);

      repeat (3) tick();
      set_in(1'b0, 1'b1, 1'b0, 3'b111, 9'h004, 16'h0, 3'b000);
      tick();
      idle();
      chk("squash_hlt_addr", bus.imem_addr, 16'h0010);
      chk("squash_hlt_flag", 16'(bus.halted), 16'h0000);
      chk("squash_hlt_valid", 16'(bus.if_id_valid), 16'h0000);
      tick();
      chk("squash_next", bus.imem_addr, 16'h0012);

      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 99) < 5) w[15:12] = 4'hF;
         else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
         mem[i] = w;
      end
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst = (m_halt && $urandom_range(0, 7) == 0) ||
               ($urandom_range(0, 199) == 0);
         set_in($urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0,
                1'($urandom),
                3'($urandom),
                9'($urandom),
                16'($urandom),
                3'($urandom));
         tick();
      end
      rst = 1'b0;
      idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
